// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester id and port count.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is granted.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  req_id_t            last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o    = '0;
    gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port Data_Memory, with round-robin
// tie-break, bounded burst lock and a registered one-cycle read response per port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DAT_WIDTH-1:0]  r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DAT_WIDTH-1:0]  r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DAT_WIDTH-1:0]  r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DAT_WIDTH-1:0]  r1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DAT_WIDTH-1:0]  mem_rdata
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  arb_state_t          state_q, state_d;
  req_id_t             rr_last_q, rr_last_d;
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DAT_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [NUM_REQ-1:0]  pick;
  logic [NUM_REQ-1:0]  gnt;
  req_id_t             win;
  logic                we_sel;
  logic                lock_sel;

  rr_pick2 u_pick (
    .req_i  ({r1_req, r0_req}),
    .last_i (rr_last_q),
    .gnt_o  (pick)
  );

  // While locked the owner alone may be granted, even if it is idle this cycle.
  always_comb begin
    gnt = '0;
    case (state_q)
      IDLE:    gnt = pick;
      LOCK0:   gnt[0] = r0_req;
      LOCK1:   gnt[1] = r1_req;
      default: gnt = '0;
    endcase
  end

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];
  assign win    = gnt[1];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    we_sel    = 1'b0;
    lock_sel  = 1'b0;
    if (gnt[0]) begin
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
      we_sel    = r0_we;
      lock_sel  = r0_lock;
    end else if (gnt[1]) begin
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
      we_sel    = r1_we;
      lock_sel  = r1_lock;
    end
  end

  assign mem_write = (|gnt) & we_sel;
  assign mem_read  = (|gnt) & ~we_sel;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          rr_last_d = win;
          if (lock_sel && LOCK_EN) begin
            state_d    = win ? LOCK1 : LOCK0;
            lock_cnt_d = LCW'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (|gnt) begin
          if (!lock_sel) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LCW'(MAX_LOCK - 1)) begin
            // Forced release: the owner becomes rr_last so the other side wins the next tie.
            state_d    = IDLE;
            rr_last_d  = win;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rvalid_d    = '0;
    rvalid_d[0] = gnt[0] & ~r0_we;
    rvalid_d[1] = gnt[1] & ~r1_we;
    rdata0_d    = rvalid_d[0] ? mem_rdata : rdata0_q;
    rdata1_d    = rvalid_d[1] ? mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

  // A waiting requester must keep its request and fields stable until granted.
  a_r0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r0_req && !r0_gnt) |=> (r0_req && $stable({r0_we, r0_lock, r0_addr, r0_wdata})));
  a_r1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r1_req && !r1_gnt) |=> (r1_req && $stable({r1_we, r1_lock, r1_addr, r1_wdata})));
  a_onehot_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(r0_gnt && r1_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small Data_Memory model (64 words, addr mod 64).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Preload while reset is held: mem[i]=i, except mem[7]=12.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      mem[7] <= 32'd12;
    end else if (mem_write) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:0]];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    next_cycle();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0)
      $display("FAIL reset_rvalid r0=%b r1=%b want 0 0", r0_rvalid, r1_rvalid); else n_pass++;
    n_chk++; if (r0_rdata !== 32'd0 || r1_rdata !== 32'd0)
      $display("FAIL reset_rdata r0=%h r1=%h want 0 0", r0_rdata, r1_rdata); else n_pass++;
    n_chk++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0)
      $display("FAIL reset_gnt r0=%b r1=%b want 0 0", r0_gnt, r1_gnt); else n_pass++;
    n_chk++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_write !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL idle_mem addr=%h wdata=%h we=%b re=%b want all 0", mem_addr, mem_wdata, mem_write, mem_read);
    else n_pass++;
  endtask

  task automatic test_read();
    r0_req = 1; r0_we = 0; r0_addr = 32'd7;
    #1;
    n_chk++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0)
      $display("FAIL read_gnt r0=%b r1=%b want 1 0", r0_gnt, r1_gnt); else n_pass++;
    n_chk++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'd7)
      $display("FAIL read_mem re=%b we=%b addr=%h want 1 0 7", mem_read, mem_write, mem_addr); else n_pass++;
    next_cycle();
    r0_req = 0;
    n_chk++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd12 || r1_rvalid !== 1'b0)
      $display("FAIL read_resp rvalid=%b rdata=%0d r1v=%b want 1 12 0", r0_rvalid, r0_rdata, r1_rvalid);
    else n_pass++;
    next_cycle();
    n_chk++; if (r0_rvalid !== 1'b0 || r0_rdata !== 32'd12)
      $display("FAIL read_hold rvalid=%b rdata=%0d want 0 12", r0_rvalid, r0_rdata); else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    r0_req = 1; r0_we = 0; r0_addr = 32'd3;
    r1_req = 1; r1_we = 0; r1_addr = 32'd5;
    #1;
    n_chk++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0)
      $display("FAIL tie_first r0=%b r1=%b want 1 0", r0_gnt, r1_gnt); else n_pass++;
    next_cycle();
    r0_req = 0;
    #1;
    n_chk++; if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0)
      $display("FAIL tie_second r0=%b r1=%b want 0 1", r0_gnt, r1_gnt); else n_pass++;
    n_chk++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd3 || r1_rvalid !== 1'b0)
      $display("FAIL tie_r0_resp v=%b d=%0d r1v=%b want 1 3 0", r0_rvalid, r0_rdata, r1_rvalid); else n_pass++;
    next_cycle();
    r1_req = 0;
    n_chk++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'd5 || r0_rvalid !== 1'b0)
      $display("FAIL tie_r1_resp v=%b d=%0d r0v=%b want 1 5 0", r1_rvalid, r1_rdata, r0_rvalid); else n_pass++;
    next_cycle();
  endtask

  task automatic test_write_read();
    r0_req = 1; r0_we = 1; r0_addr = 32'd10; r0_wdata = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (r0_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_drive gnt=%b we=%b re=%b wdata=%h want 1 1 0 deadbeef", r0_gnt, mem_write, mem_read, mem_wdata);
    else n_pass++;
    next_cycle();
    r0_req = 0; r0_we = 0;
    r1_req = 1; r1_we = 0; r1_addr = 32'd10;
    #1;
    n_chk++; if (mem_write !== 1'b0 || r1_gnt !== 1'b1 || r0_rvalid !== 1'b0)
      $display("FAIL wr_one_cycle we=%b r1gnt=%b r0v=%b want 0 1 0", mem_write, r1_gnt, r0_rvalid); else n_pass++;
    next_cycle();
    r1_req = 0;
    n_chk++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_readback v=%b d=%h want 1 deadbeef", r1_rvalid, r1_rdata); else n_pass++;
    next_cycle();
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_g [11];
    int r1_left = 10;
    bit r0_pend = 0;
    for (int k = 0; k < 11; k++) exp_g[k] = (k == 8) ? 2'b01 : 2'b10;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 9) begin
        n_chk++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h101)
          $display("FAIL lock_r0_read v=%b d=%h want 1 101", r0_rvalid, r0_rdata); else n_pass++;
      end
      r1_req = (r1_left > 0); r1_we = 1; r1_lock = (r1_left > 1);
      r1_addr = 32'd40 + 32'(10 - r1_left); r1_wdata = 32'h100 + 32'(10 - r1_left);
      r0_req = r0_pend; r0_we = 0; r0_lock = 0; r0_addr = 32'd41;
      #1;
      n_chk++; if ({r1_gnt, r0_gnt} !== exp_g[cyc])
        $display("FAIL lock_gnt_c%0d got r1r0=%b want %b", cyc, {r1_gnt, r0_gnt}, exp_g[cyc]); else n_pass++;
      if (r1_gnt) r1_left--;
      if (r0_gnt) r0_pend = 0;
      if (cyc == 0) r0_pend = 1;
      next_cycle();
    end
    idle_inputs();
    n_chk++; if (r1_left !== 0)
      $display("FAIL lock_beats_left got %0d want 0", r1_left); else n_pass++;
    r0_req = 1; r0_addr = 32'd47;
    #1;
    n_chk++; if (r0_gnt !== 1'b1)
      $display("FAIL lock_released r0_gnt=%b want 1", r0_gnt); else n_pass++;
    next_cycle();
    idle_inputs();
    n_chk++; if (r0_rdata !== 32'h107)
      $display("FAIL lock_last_write d=%h want 107", r0_rdata); else n_pass++;
  endtask

  task automatic test_wrap();
    r0_req = 1; r0_we = 1; r0_addr = 32'd66; r0_wdata = 32'h55;
    #1;
    n_chk++; if (mem_addr !== 32'd66 || mem_write !== 1'b1)
      $display("FAIL wrap_addr addr=%0d we=%b want 66 1", mem_addr, mem_write); else n_pass++;
    next_cycle();
    r0_we = 0; r0_addr = 32'd2;
    next_cycle();
    r0_req = 0;
    n_chk++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h55)
      $display("FAIL wrap_read v=%b d=%h want 1 55", r0_rvalid, r0_rdata); else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    r0_req = 1; r0_we = 0; r0_addr = 32'd7;
    #1;
    n_chk++; if (r0_gnt !== 1'b1)
      $display("FAIL midrst_gnt r0=%b want 1", r0_gnt); else n_pass++;
    rst_n = 0;
    next_cycle();
    r0_req = 0;
    n_chk++; if (r0_rvalid !== 1'b0 || r0_rdata !== 32'd0)
      $display("FAIL midrst_drop v=%b d=%h want 0 0", r0_rvalid, r0_rdata); else n_pass++;
    next_cycle();
    rst_n = 1;
    r0_req = 1; r0_addr = 32'd3;
    r1_req = 1; r1_we = 0; r1_addr = 32'd5;
    #1;
    n_chk++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0)
      $display("FAIL midrst_tie r0=%b r1=%b want 1 0", r0_gnt, r1_gnt); else n_pass++;
    next_cycle();
    r0_req = 0;
    #1;
    n_chk++; if (r1_gnt !== 1'b1 || r0_rdata !== 32'd3)
      $display("FAIL midrst_after r1gnt=%b r0d=%0d want 1 3", r1_gnt, r0_rdata); else n_pass++;
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_read();
    test_tie();
    test_write_read();
    test_lock_burst();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
